wavetable_ram_scheduler: RTL



---
 rtl/wavetable_ram_scheduler_pkg.sv | 25 ++
 rtl/wavetable_phase_bank.sv | 45 ++++
 rtl/wavetable_ram_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wavetable_ram_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_ram_scheduler_pkg
// Brief    : shared defaults, state encodings and reset sample for the scheduler
// Revision : 1.0
// ============================================================================
package wavetable_ram_scheduler_pkg;

    localparam int DEFAULT_NUM_VOICES  = 4;
    localparam int DEFAULT_PHASE_WIDTH = 24;
    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_TABLE_BITS  = 8;

    typedef logic [1:0] state_t;

    localparam state_t STATE_IDLE  = 2'd0;
    localparam state_t STATE_WRITE = 2'd1;
    localparam state_t STATE_READ  = 2'd2;
    localparam state_t STATE_DRAIN = 2'd3;

    localparam logic [7:0] SAMPLE_RESET = 8'h80;

endpackage
`default_nettype wire

// File: rtl/wavetable_phase_bank.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_phase_bank
// Brief    : per-voice phase accumulators, one indexed voice advanced per strobe
// Revision : 1.0
// ============================================================================
module wavetable_phase_bank
    import wavetable_ram_scheduler_pkg::*;
#(
    parameter int NUM_VOICES  = DEFAULT_NUM_VOICES,
    parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
    parameter int TABLE_BITS  = DEFAULT_TABLE_BITS,
    parameter int VOICE_WIDTH = 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [VOICE_WIDTH-1:0] i_voice,
    input  logic                   i_update,
    input  logic [PHASE_WIDTH-1:0] i_increment,
    output logic [TABLE_BITS-1:0]  o_phase_index
);

    logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] r_phase_q;
    logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] w_phase_d;

    // Table index comes from the pre-increment phase of the selected voice.
    assign o_phase_index = r_phase_q[i_voice][PHASE_WIDTH-1 -: TABLE_BITS];

    always_comb begin
        w_phase_d = r_phase_q;
        if (i_update) begin
            w_phase_d[i_voice] = r_phase_q[i_voice] + i_increment;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_phase_q <= '0;
        end else begin
            r_phase_q <= w_phase_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wavetable_ram_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_ram_scheduler
// Brief    : time-shares the wavetable RAM between per-tick voice reads and host writes
// Revision : 1.0
// ============================================================================
module wavetable_ram_scheduler
    import wavetable_ram_scheduler_pkg::*;
#(
    parameter int NUM_VOICES  = DEFAULT_NUM_VOICES,
    parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int TABLE_BITS  = DEFAULT_TABLE_BITS
) (
    input  logic                                         i_clock,
    input  logic                                         i_reset,
    input  logic                                         i_sample_tick,
    input  logic [NUM_VOICES*PHASE_WIDTH-1:0]            i_tuning,
    input  logic [NUM_VOICES*(ADDR_WIDTH-TABLE_BITS)-1:0] i_wave_select,
    input  logic                                         i_host_write_req,
    input  logic [ADDR_WIDTH-1:0]                        i_host_address,
    input  logic [DATA_WIDTH-1:0]                        i_host_data,
    output logic                                         o_host_write_ack,
    output logic [ADDR_WIDTH-1:0]                        o_ram_address,
    output logic [DATA_WIDTH-1:0]                        o_ram_data,
    output logic                                         o_ram_write_enable,
    input  logic [DATA_WIDTH-1:0]                        i_ram_data,
    output logic [NUM_VOICES*DATA_WIDTH-1:0]             o_samples,
    output logic                                         o_frame_done,
    output logic                                         o_overrun
);

    localparam int SEL_WIDTH   = ADDR_WIDTH - TABLE_BITS;
    localparam int VOICE_WIDTH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VOICE_WIDTH-1:0] c_LAST_VOICE   = VOICE_WIDTH'(NUM_VOICES - 1);
    localparam logic [DATA_WIDTH-1:0]  c_SAMPLE_RESET = DATA_WIDTH'(SAMPLE_RESET);

    state_t                         r_state_q,       w_state_d;
    logic [VOICE_WIDTH-1:0]         r_voice_q,       w_voice_d;
    logic                           r_drain_q,       w_drain_d;
    logic                           r_pending_q,     w_pending_d;
    logic                           r_overrun_q,     w_overrun_d;
    logic [ADDR_WIDTH-1:0]          r_ram_address_q, w_ram_address_d;
    logic [DATA_WIDTH-1:0]          r_ram_data_q,    w_ram_data_d;
    logic                           r_ram_we_q,      w_ram_we_d;
    logic                           r_ack_q,         w_ack_d;
    logic                           r_frame_done_q,  w_frame_done_d;
    logic                           r_iss_valid_q,   w_iss_valid_d;
    logic [VOICE_WIDTH-1:0]         r_iss_voice_q,   w_iss_voice_d;
    logic                           r_rd_valid_q,    w_rd_valid_d;
    logic [VOICE_WIDTH-1:0]         r_rd_voice_q,    w_rd_voice_d;
    logic [NUM_VOICES*DATA_WIDTH-1:0] r_samples_q,   w_samples_d;

    logic                   w_start;
    logic                   w_issue;
    logic [VOICE_WIDTH-1:0] w_voice;
    logic [PHASE_WIDTH-1:0] w_tuning;
    logic [SEL_WIDTH-1:0]   w_select;
    logic [TABLE_BITS-1:0]  w_phase_index;

    // Voice 0 is issued on the tick edge itself, so IDLE also counts as an issue cycle.
    assign w_start  = i_sample_tick || r_pending_q;
    assign w_issue  = ((r_state_q == STATE_IDLE) && w_start) || (r_state_q == STATE_READ);
    assign w_voice  = (r_state_q == STATE_READ) ? r_voice_q : '0;
    assign w_tuning = i_tuning[w_voice*PHASE_WIDTH +: PHASE_WIDTH];
    assign w_select = i_wave_select[w_voice*SEL_WIDTH +: SEL_WIDTH];

    wavetable_phase_bank #(
        .NUM_VOICES  (NUM_VOICES),
        .PHASE_WIDTH (PHASE_WIDTH),
        .TABLE_BITS  (TABLE_BITS),
        .VOICE_WIDTH (VOICE_WIDTH)
    ) u_phase_bank (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_voice       (w_voice),
        .i_update      (w_issue),
        .i_increment   (w_tuning),
        .o_phase_index (w_phase_index)
    );

    always_comb begin
        w_state_d       = r_state_q;
        w_voice_d       = r_voice_q;
        w_drain_d       = r_drain_q;
        w_pending_d     = r_pending_q;
        w_overrun_d     = r_overrun_q;
        w_ram_address_d = r_ram_address_q;
        w_ram_data_d    = r_ram_data_q;
        w_ram_we_d      = 1'b0;
        w_ack_d         = 1'b0;
        w_frame_done_d  = 1'b0;
        w_samples_d     = r_samples_q;
        // Two-stage tag follows each read through the RAM's registered output.
        w_iss_valid_d   = w_issue;
        w_iss_voice_d   = w_voice;
        w_rd_valid_d    = r_iss_valid_q;
        w_rd_voice_d    = r_iss_voice_q;

        if (r_rd_valid_q) begin
            w_samples_d[r_rd_voice_q*DATA_WIDTH +: DATA_WIDTH] = i_ram_data;
        end
        if (w_issue) begin
            w_ram_address_d = {w_select, w_phase_index};
        end

        case (r_state_q)
            STATE_IDLE: begin
                if (w_start) begin
                    w_pending_d = 1'b0;
                    w_voice_d   = VOICE_WIDTH'(1);
                    w_drain_d   = 1'b0;
                    w_state_d   = (NUM_VOICES == 1) ? STATE_DRAIN : STATE_READ;
                end else if (i_host_write_req) begin
                    w_state_d       = STATE_WRITE;
                    w_ram_address_d = i_host_address;
                    w_ram_data_d    = i_host_data;
                    w_ram_we_d      = 1'b1;
                    w_ack_d         = 1'b1;
                end
            end
            STATE_WRITE: begin
                w_state_d = STATE_IDLE;
                if (i_sample_tick) begin
                    if (r_pending_q) begin
                        w_overrun_d = 1'b1;
                    end else begin
                        w_pending_d = 1'b1;
                    end
                end
            end
            STATE_READ: begin
                if (i_sample_tick) begin
                    w_overrun_d = 1'b1;
                end
                if (r_voice_q == c_LAST_VOICE) begin
                    w_state_d = STATE_DRAIN;
                    w_drain_d = 1'b0;
                end else begin
                    w_voice_d = r_voice_q + 1'b1;
                end
            end
            default: begin
                if (i_sample_tick) begin
                    w_overrun_d = 1'b1;
                end
                w_drain_d = 1'b1;
                if (r_drain_q) begin
                    w_state_d      = STATE_IDLE;
                    w_frame_done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state_q       <= STATE_IDLE;
            r_voice_q       <= '0;
            r_drain_q       <= 1'b0;
            r_pending_q     <= 1'b0;
            r_overrun_q     <= 1'b0;
            r_ram_address_q <= '0;
            r_ram_data_q    <= '0;
            r_ram_we_q      <= 1'b0;
            r_ack_q         <= 1'b0;
            r_frame_done_q  <= 1'b0;
            r_iss_valid_q   <= 1'b0;
            r_iss_voice_q   <= '0;
            r_rd_valid_q    <= 1'b0;
            r_rd_voice_q    <= '0;
            r_samples_q     <= {NUM_VOICES{c_SAMPLE_RESET}};
        end else begin
            r_state_q       <= w_state_d;
            r_voice_q       <= w_voice_d;
            r_drain_q       <= w_drain_d;
            r_pending_q     <= w_pending_d;
            r_overrun_q     <= w_overrun_d;
            r_ram_address_q <= w_ram_address_d;
            r_ram_data_q    <= w_ram_data_d;
            r_ram_we_q      <= w_ram_we_d;
            r_ack_q         <= w_ack_d;
            r_frame_done_q  <= w_frame_done_d;
            r_iss_valid_q   <= w_iss_valid_d;
            r_iss_voice_q   <= w_iss_voice_d;
            r_rd_valid_q    <= w_rd_valid_d;
            r_rd_voice_q    <= w_rd_voice_d;
            r_samples_q     <= w_samples_d;
        end
    end

    assign o_host_write_ack   = r_ack_q;
    assign o_ram_address      = r_ram_address_q;
    assign o_ram_data         = r_ram_data_q;
    assign o_ram_write_enable = r_ram_we_q;
    assign o_samples          = r_samples_q;
    assign o_frame_done       = r_frame_done_q;
    assign o_overrun          = r_overrun_q;

endmodule
`default_nettype wire
